fix_mul: RTL and testbench

- Sequential shift-add fixed-point multiplier, the inverse operation of the team's sequential fixed-point divider.
- Both operands and the result use the divider's output format:
  - int word: sign at MSB, N-1-bit integer magnitude below it.
  - separate Q-bit fraction word.
- Typical use: rebuild the dividend from quotient × divisor, and general scaling in the datapath.
- Takes one operand pair per start and computes one magnitude bit per cycle.

---
 rtl/fix_pkg.sv | 38 +++
 rtl/fix_mul_round_sat.sv | 74 +++++++
 rtl/fix_mul.sv | 164 ++++++++++++++++
 tb/tb_fix_mul.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// -----------------------------------------------------------------------------
// fix_pkg
// Shared fixed-point definitions used by the sequential multiplier and the
// sequential divider.
//
// Number format (shared by operands and results):
//   int word  : sign at MSB, N-1 bit integer magnitude below it
//   frac word : separate Q-bit fraction
//
// Contents:
//   FIX_N, FIX_Q     default word widths
//   FIX_MAG_W        magnitude width (integer magnitude + fraction)
//   fix_t            packed {sign, mag_int, frac} view of one number
//   fix_mul_state_e  multiplier control states
//   fix_mag_w()      magnitude width for arbitrary N/Q
// -----------------------------------------------------------------------------
package fix_pkg;

    localparam int FIX_N     = 33;
    localparam int FIX_Q     = 33;
    localparam int FIX_MAG_W = FIX_N - 1 + FIX_Q;

    typedef struct packed {
        logic               sign;
        logic [FIX_N-2:0]   mag_int;
        logic [FIX_Q-1:0]   frac;
    } fix_t;

    typedef enum logic {
        FIX_MUL_IDLE,
        FIX_MUL_RUN
    } fix_mul_state_e;

    function automatic int fix_mag_w(input int n, input int q);
        return n - 1 + q;
    endfunction

endpackage

// File: rtl/fix_mul_round_sat.sv
// -----------------------------------------------------------------------------
// fix_mul_round_sat
// Combinational result stage of the fixed-point multiplier. Takes the full
// 2M-bit magnitude product (units of 2^-2Q) and the result sign, and produces
// the final sign/int/frac words plus the overflow flag.
//
// Optional feature macro: FIX_MUL_ROUND_EN
//   defined   : round half-up on the first discarded fraction bit; a carry out
//               of the kept field counts as overflow
//   undefined : truncate the discarded fraction bits
//
// Ports:
//   p         in   2M   full magnitude product
//   sign      in   1    product sign (XOR of operand signs)
//   res_int   out  N    result sign + integer magnitude
//   res_frac  out  Q    result fraction
//   overflow  out  1    result saturated
// -----------------------------------------------------------------------------
module fix_mul_round_sat
    import fix_pkg::*;
#(
    parameter int N = FIX_N,
    parameter int Q = FIX_Q
) (
    input  logic [2*(N-1+Q)-1:0] p,
    input  logic                 sign,
    output logic [N-1:0]         res_int,
    output logic [Q-1:0]         res_frac,
    output logic                 overflow
);

    localparam int MW  = fix_mag_w(N, Q);
    localparam int PW  = 2 * MW;
    localparam int KLO = Q;
    localparam int KHI = 2 * Q + N - 2;

    logic [MW-1:0] k;
    logic          high_nonzero;
    logic          round_carry;
    logic [MW-1:0] mag_pre;
    logic [MW-1:0] mag;

    // The kept field K sits Q bits above the LSB; anything above it cannot be
    // represented in the N-1 integer bits.
    assign k            = p[KHI:KLO];
    assign high_nonzero = |p[PW-1:KHI+1];

`ifdef FIX_MUL_ROUND_EN
    logic [MW:0] k_rounded;
    logic        unused_low_bits;

    // Half-up: add the first discarded bit; the extra MSB catches the carry.
    assign k_rounded       = {1'b0, k} + {{MW{1'b0}}, p[Q-1]};
    assign round_carry     = k_rounded[MW];
    assign mag_pre         = k_rounded[MW-1:0];
    assign unused_low_bits = ^p[Q-2:0];
`else
    logic unused_low_bits;

    assign round_carry     = 1'b0;
    assign mag_pre         = k;
    assign unused_low_bits = ^p[Q-1:0];
`endif

    // Saturate the whole magnitude on overflow but keep the sign; a zero
    // magnitude never carries a negative sign.
    always_comb begin
        overflow = high_nonzero | round_carry;
        mag      = overflow ? {MW{1'b1}} : mag_pre;
        res_int  = {sign & (|mag), mag[MW-1:Q]};
        res_frac = mag[Q-1:0];
    end

endmodule

// File: rtl/fix_mul.sv
// -----------------------------------------------------------------------------
// fix_mul
// Sequential shift-add fixed-point multiplier (inverse of the sequential
// fixed-point divider). One magnitude bit of operand B is consumed per clock,
// LSB first, so an operation takes M = N-1+Q cycles after the start edge.
//
// Optional feature macro: FIX_MUL_ROUND_EN (round half-up instead of
// truncate; implemented in fix_mul_round_sat, no extra latency).
//
// Ports:
//   clk             in   1  clock, rising edge
//   rst             in   1  asynchronous active-high reset
//   i_a_int         in   N  operand A sign [N-1] + integer magnitude
//   i_a_frac        in   Q  operand A fraction
//   i_b_int         in   N  operand B sign [N-1] + integer magnitude
//   i_b_frac        in   Q  operand B fraction
//   i_start         in   1  start request, accepted only while idle
//   o_product_int   out  N  result sign + integer magnitude
//   o_product_frac  out  Q  result fraction
//   o_overflow      out  1  result saturated
//   o_complete      out  1  1 = idle with valid result, 0 = busy
// -----------------------------------------------------------------------------
module fix_mul
    import fix_pkg::*;
#(
    parameter int N = FIX_N,
    parameter int Q = FIX_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_a_int,
    input  logic [Q-1:0] i_a_frac,
    input  logic [N-1:0] i_b_int,
    input  logic [Q-1:0] i_b_frac,
    input  logic         i_start,
    output logic [N-1:0] o_product_int,
    output logic [Q-1:0] o_product_frac,
    output logic         o_overflow,
    output logic         o_complete
);

    localparam int MW = fix_mag_w(N, Q);
    localparam int PW = 2 * MW;
    localparam int CW = $clog2(MW);

    fix_mul_state_e state;
    fix_mul_state_e state_next;

    logic          load;
    logic          step;
    logic          finish;

    logic [MW-1:0] a_mag;
    logic [MW-1:0] b_mag;
    logic          sign;
    logic [PW-1:0] acc;
    logic [CW-1:0] count;

    logic [MW-1:0] addend;
    logic [MW:0]   sum;
    logic [PW-1:0] acc_next;
    logic          unused_acc_lsb;

    logic [N-1:0]  res_int;
    logic [Q-1:0]  res_frac;
    logic          res_overflow;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FIX_MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control: a start is only honoured in IDLE, so requests while busy are
    // dropped without touching the latched operands. The RUN edge that sees
    // count==0 is the last bit and also registers the result.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            FIX_MUL_IDLE: begin
                if (i_start) begin
                    load       = 1'b1;
                    state_next = FIX_MUL_RUN;
                end
            end
            FIX_MUL_RUN: begin
                step = 1'b1;
                if (count == '0) begin
                    finish     = 1'b1;
                    state_next = FIX_MUL_IDLE;
                end
            end
            default: state_next = FIX_MUL_IDLE;
        endcase
    end

    // Right-shifting shift-add: the partial sum is added into the upper half
    // and the whole accumulator moves down one bit. After M steps the lower
    // half has filled with the low product bits and acc holds A*B exactly.
    // The bit falling off the bottom is always one of the initial zeros.
    always_comb begin
        addend   = b_mag[0] ? a_mag : '0;
        sum      = {1'b0, acc[PW-1:MW]} + {1'b0, addend};
        acc_next = {sum, acc[MW-1:1]};
    end

    assign unused_acc_lsb = acc[0];

    // The result stage sees the product as it will be after the final step,
    // so rounding/saturation costs no extra cycle.
    fix_mul_round_sat #(
        .N(N),
        .Q(Q)
    ) u_round_sat (
        .p        (acc_next),
        .sign     (sign),
        .res_int  (res_int),
        .res_frac (res_frac),
        .overflow (res_overflow)
    );

    // Operand, accumulator and counter registers; results only change on the
    // finishing edge so they hold steady through the next operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag          <= '0;
            b_mag          <= '0;
            sign           <= 1'b0;
            acc            <= '0;
            count          <= '0;
            o_product_int  <= '0;
            o_product_frac <= '0;
            o_overflow     <= 1'b0;
        end else begin
            if (load) begin
                a_mag <= {i_a_int[N-2:0], i_a_frac};
                b_mag <= {i_b_int[N-2:0], i_b_frac};
                sign  <= i_a_int[N-1] ^ i_b_int[N-1];
                acc   <= '0;
                count <= CW'(MW - 1);
            end else if (step) begin
                acc   <= acc_next;
                b_mag <= b_mag >> 1;
                if (!finish) begin
                    count <= count - 1'b1;
                end
            end
            if (finish) begin
                o_product_int  <= res_int;
                o_product_frac <= res_frac;
                o_overflow     <= res_overflow;
            end
        end
    end

    assign o_complete = (state == FIX_MUL_IDLE);

endmodule

// File: tb/tb_fix_mul.sv
// -----------------------------------------------------------------------------
// tb_fix_mul
// Self-checking bench for fix_mul at default widths. Directed cases use
// hand-computed constants; random cases use a plain-arithmetic reference
// model (full wide multiply, then extract/round/saturate from the format
// rules). Honours FIX_MUL_ROUND_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_fix_mul;

    localparam int N  = 33;
    localparam int Q  = 33;
    localparam int MW = N - 1 + Q;
    localparam int PW = 2 * MW;
    localparam int LAT = MW;

    logic         clk;
    logic         rst;
    logic [N-1:0] a_int;
    logic [Q-1:0] a_frac;
    logic [N-1:0] b_int;
    logic [Q-1:0] b_frac;
    logic         start;
    logic [N-1:0] product_int;
    logic [Q-1:0] product_frac;
    logic         overflow;
    logic         complete;

    int vectors;
    int miscompares;

    fix_mul #(
        .N(N),
        .Q(Q)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_a_int        (a_int),
        .i_a_frac       (a_frac),
        .i_b_int        (b_int),
        .i_b_frac       (b_frac),
        .i_start        (start),
        .o_product_int  (product_int),
        .o_product_frac (product_frac),
        .o_overflow     (overflow),
        .o_complete     (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact wide product, then apply the result format rules.
    function automatic void ref_mul(
        input  logic [N-1:0] ai,
        input  logic [Q-1:0] af,
        input  logic [N-1:0] bi,
        input  logic [Q-1:0] bf,
        output logic [N-1:0] ri,
        output logic [Q-1:0] rf,
        output logic         ro
    );
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [PW-1:0] p;
        logic [PW-1:0] k;
        logic [PW-1:0] mask;
        logic [MW-1:0] mag;
        logic          s;
        a    = {{(PW-MW){1'b0}}, ai[N-2:0], af};
        b    = {{(PW-MW){1'b0}}, bi[N-2:0], bf};
        p    = a * b;
        mask = {{(PW-MW){1'b0}}, {MW{1'b1}}};
        ro   = (p >> (2*Q + N - 1)) != 0;
        k    = (p >> Q) & mask;
`ifdef FIX_MUL_ROUND_EN
        k = k + {{(PW-1){1'b0}}, p[Q-1]};
        if (k > mask) ro = 1'b1;
`endif
        mag = ro ? {MW{1'b1}} : k[MW-1:0];
        s   = (ai[N-1] ^ bi[N-1]) && (mag != 0);
        ri  = {s, mag[MW-1:Q]};
        rf  = mag[Q-1:0];
    endfunction

    task automatic drive_start(
        input logic [N-1:0] ai, input logic [Q-1:0] af,
        input logic [N-1:0] bi, input logic [Q-1:0] bf
    );
        @(negedge clk);
        a_int  = ai;
        a_frac = af;
        b_int  = bi;
        b_frac = bf;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until o_complete rises, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!complete && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        #12;
        vectors += 4;
        if (complete !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_complete: got %b expected 1", complete);
        end
        if (product_int !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_int: got %h expected 0", product_int);
        end
        if (product_frac !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_frac: got %h expected 0", product_frac);
        end
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0] dai[5];
        logic [Q-1:0] daf[5];
        logic [N-1:0] dbi[5];
        logic [Q-1:0] dbf[5];
        logic [N-1:0] eri[5];
        logic [Q-1:0] erf[5];
        logic         ero[5];
        int           lat;
        // 2.0 x 3.5 = 7.0
        dai[0] = 33'd2;            daf[0] = '0;
        dbi[0] = 33'd3;            dbf[0] = 33'h1_0000_0000;
        eri[0] = 33'd7;            erf[0] = '0;            ero[0] = 1'b0;
        // -1.5 x 2.0 = -3.0
        dai[1] = {1'b1, 32'd1};    daf[1] = 33'h1_0000_0000;
        dbi[1] = 33'd2;            dbf[1] = '0;
        eri[1] = {1'b1, 32'd3};    erf[1] = '0;            ero[1] = 1'b0;
        // -0 x 5.0 = +0
        dai[2] = {1'b1, 32'd0};    daf[2] = '0;
        dbi[2] = 33'd5;            dbf[2] = '0;
        eri[2] = '0;               erf[2] = '0;            ero[2] = 1'b0;
        // -2^31 x 4.0 saturates, sign kept
        dai[3] = {1'b1, 32'h8000_0000}; daf[3] = '0;
        dbi[3] = 33'd4;            dbf[3] = '0;
        eri[3] = {1'b1, 32'hFFFF_FFFF}; erf[3] = {Q{1'b1}}; ero[3] = 1'b1;
        // 2^-33 x 0.5: exact half LSB
        dai[4] = '0;               daf[4] = 33'd1;
        dbi[4] = '0;               dbf[4] = 33'h1_0000_0000;
        eri[4] = '0;               ero[4] = 1'b0;
`ifdef FIX_MUL_ROUND_EN
        erf[4] = 33'd1;
`else
        erf[4] = 33'd0;
`endif
        for (int i = 0; i < 5; i++) begin
            drive_start(dai[i], daf[i], dbi[i], dbf[i]);
            wait_done(lat);
            vectors += 4;
            if (lat !== LAT) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
            if (product_int !== eri[i]) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_int: got %h expected %h", i, product_int, eri[i]);
            end
            if (product_frac !== erf[i]) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_frac: got %h expected %h", i, product_frac, erf[i]);
            end
            if (overflow !== ero[i]) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_overflow: got %b expected %b", i, overflow, ero[i]);
            end
        end
    endtask

    function automatic logic [N-1:0] rand_int();
        logic [N-1:0] r;
        logic [31:0]  m;
        m           = $urandom() >> $urandom_range(0, 32);
        r[N-2:0]    = (N-1)'(m);
        r[N-1]      = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [Q-1:0] rand_frac();
        logic [63:0] t;
        logic [Q-1:0] f;
        t = {$urandom(), $urandom()};
        f = t[Q-1:0];
        return f >> $urandom_range(0, Q);
    endfunction

    task automatic test_random();
        logic [N-1:0] ai, bi, eri;
        logic [Q-1:0] af, bf, erf;
        logic         ero;
        int           lat;
        for (int i = 0; i < 24; i++) begin
            ai = rand_int();  af = rand_frac();
            bi = rand_int();  bf = rand_frac();
            ref_mul(ai, af, bi, bf, eri, erf, ero);
            drive_start(ai, af, bi, bf);
            wait_done(lat);
            vectors += 4;
            if (lat !== LAT) begin
                miscompares++;
                $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
            if (product_int !== eri) begin
                miscompares++;
                $display("[TB] FAIL random%0d_int: got %h expected %h", i, product_int, eri);
            end
            if (product_frac !== erf) begin
                miscompares++;
                $display("[TB] FAIL random%0d_frac: got %h expected %h", i, product_frac, erf);
            end
            if (overflow !== ero) begin
                miscompares++;
                $display("[TB] FAIL random%0d_overflow: got %b expected %b", i, overflow, ero);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        // 2.0 x 3.5 with a 5.0 x 5.0 request injected mid-run
        drive_start(33'd2, '0, 33'd3, 33'h1_0000_0000);
        repeat (9) @(posedge clk);
        #1;
        a_int = 33'd5; a_frac = '0; b_int = 33'd5; b_frac = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        vectors += 3;
        if (lat + 10 !== LAT) begin
            miscompares++;
            $display("[TB] FAIL busy_latency: got %0d expected %0d", lat + 10, LAT);
        end
        if (product_int !== 33'd7) begin
            miscompares++;
            $display("[TB] FAIL busy_int: got %h expected %h", product_int, 33'd7);
        end
        if (product_frac !== '0) begin
            miscompares++;
            $display("[TB] FAIL busy_frac: got %h expected 0", product_frac);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        // start held high: 3.0 x -2.0 immediately followed by 0.25 x 6.0
        drive_start(33'd3, '0, {1'b1, 32'd2}, '0);
        start = 1'b1;
        wait_done(lat);
        a_int = '0; a_frac = 33'h0_8000_0000; b_int = 33'd6; b_frac = '0;
        vectors += 3;
        if (product_int !== {1'b1, 32'd6}) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_int: got %h expected %h", product_int, {1'b1, 32'd6});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (complete !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_restart: got complete=%b expected 0", complete);
        end
        wait_done(lat);
        if (lat !== LAT) begin
            miscompares++;
            $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, LAT);
        end
        vectors += 2;
        if (product_int !== 33'd1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_int: got %h expected %h", product_int, 33'd1);
        end
        if (product_frac !== 33'h1_0000_0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_frac: got %h expected %h", product_frac, 33'h1_0000_0000);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        drive_start(33'd7, '0, 33'd9, '0);
        repeat (9) @(posedge clk);
        #1;
        a_int = 33'd4; b_int = 33'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors += 4;
        if (complete !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_complete: got %b expected 1", complete);
        end
        if (product_int !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_int: got %h expected 0", product_int);
        end
        if (product_frac !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_frac: got %h expected 0", product_frac);
        end
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_overflow: got %b expected 0", overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_start(33'd3, '0, 33'd3, '0);
        wait_done(lat);
        vectors += 3;
        if (lat !== LAT) begin
            miscompares++;
            $display("[TB] FAIL after_rst_latency: got %0d expected %0d", lat, LAT);
        end
        if (product_int !== 33'd9) begin
            miscompares++;
            $display("[TB] FAIL after_rst_int: got %h expected %h", product_int, 33'd9);
        end
        if (product_frac !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_rst_frac_ovf: got %h/%b expected 0/0", product_frac, overflow);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a_int  = '0;
        a_frac = '0;
        b_int  = '0;
        b_frac = '0;
        start  = 1'b0;
        rst    = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
